// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of requester and Data_Memory signals around dm_arbiter.
//   slave  : arbiter side (sees requests and dm_rdata, drives grants, strobes and memory controls)
//   master : requester/memory side (the mirror image)
interface dm_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              en_DM_rd, en_DM_wr;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dm_rdata,
    output cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid,
    output rd_data, dm_addr, dm_wdata, en_DM_rd, en_DM_wr
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dm_rdata,
    input  cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid,
    input  rd_data, dm_addr, dm_wdata, en_DM_rd, en_DM_wr
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one Data_Memory port between a CPU and a debug/loader requester.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : dm_arbiter_if.slave -- cpu_*/dbg_* request/grant/rvalid, shared rd_data,
//              dm_addr/dm_wdata/en_DM_rd/en_DM_wr to memory, dm_rdata from memory
//   Macro DM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed dbg-over-cpu priority.
module dm_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  dm_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state, state_n;
  logic              owner, owner_n;
  logic              pick_dbg;
  logic              cpu_gnt_n, dbg_gnt_n, cpu_rv_n, dbg_rv_n, rd_en_n, wr_en_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rd_data_n;
`ifdef DM_ARB_RR_EN
  // last_dbg = 1 when the most recent grant went to dbg; cleared so dbg wins first after reset
  logic last_dbg;
  always_ff @(posedge clk)
    if (rst) last_dbg <= 1'b0;
    else if (state == IDLE && (bus.cpu_req || bus.dbg_req)) last_dbg <= pick_dbg;
  assign pick_dbg = bus.dbg_req && !(bus.cpu_req && last_dbg);
`else
  assign pick_dbg = bus.dbg_req;
`endif
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    cpu_gnt_n = 1'b0;
    dbg_gnt_n = 1'b0;
    cpu_rv_n  = 1'b0;
    dbg_rv_n  = 1'b0;
    rd_en_n   = 1'b0;
    wr_en_n   = 1'b0;
    addr_n    = bus.dm_addr;
    wdata_n   = bus.dm_wdata;
    rd_data_n = bus.rd_data;
    case (state)
      IDLE: if (bus.cpu_req || bus.dbg_req) begin
        state_n   = ACCESS;
        owner_n   = pick_dbg;
        dbg_gnt_n = pick_dbg;
        cpu_gnt_n = !pick_dbg;
        wr_en_n   = pick_dbg ? bus.dbg_we : bus.cpu_we;
        rd_en_n   = !wr_en_n;
        addr_n    = pick_dbg ? bus.dbg_addr : bus.cpu_addr;
        wdata_n   = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
      end
      // the registered write enable still holds the latched access type here
      ACCESS: state_n = bus.en_DM_wr ? IDLE : RESP;
      RESP: begin
        state_n   = IDLE;
        rd_data_n = bus.dm_rdata;
        dbg_rv_n  = owner;
        cpu_rv_n  = !owner;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      bus.cpu_gnt    <= 1'b0;
      bus.dbg_gnt    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dbg_rvalid <= 1'b0;
      bus.en_DM_rd   <= 1'b0;
      bus.en_DM_wr   <= 1'b0;
      bus.dm_addr    <= '0;
      bus.dm_wdata   <= '0;
      bus.rd_data    <= '0;
    end else begin
      state          <= state_n;
      owner          <= owner_n;
      bus.cpu_gnt    <= cpu_gnt_n;
      bus.dbg_gnt    <= dbg_gnt_n;
      bus.cpu_rvalid <= cpu_rv_n;
      bus.dbg_rvalid <= dbg_rv_n;
      bus.en_DM_rd   <= rd_en_n;
      bus.en_DM_wr   <= wr_en_n;
      bus.dm_addr    <= addr_n;
      bus.dm_wdata   <= wdata_n;
      bus.rd_data    <= rd_data_n;
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and random checks of dm_arbiter against a transaction-level model
module tb_dm_arbiter;
  localparam int NC = 2048;
`ifdef DM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int total = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;
  dm_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  dm_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // memory environment: returns data one cycle after a read enable, garbage otherwise
  logic [7:0] mem [256];
  bit         mem_ok [256];
  always @(posedge clk) begin
    if (bus.en_DM_wr) begin
      mem[bus.dm_addr]    <= bus.dm_wdata;
      mem_ok[bus.dm_addr] <= 1'b1;
    end
    bus.dm_rdata <= !bus.en_DM_rd ? 8'($urandom) :
                    mem_ok[bus.dm_addr] ? mem[bus.dm_addr] : (bus.dm_addr ^ 8'h3C);
  end

  // reference model: per-cycle expectations scheduled when a transaction is awarded
  logic [7:0] ref_mem [256];
  bit exp_cg [NC], exp_dg [NC], exp_wr [NC], exp_re [NC], exp_crv [NC], exp_drv [NC];
  bit ev_a [NC], ev_w [NC], ev_r [NC];
  logic [7:0] ev_av [NC], ev_wv [NC], ev_rv [NC];
  logic [7:0] cur_a, cur_w, cur_r;
  int  free_at;
  bit  last_dbg;
  bit  cpu_pend, cpu_we_v, cpu_gr, dbg_pend, dbg_we_v, dbg_gr;
  logic [7:0] cpu_addr_v, cpu_wdata_v, dbg_addr_v, dbg_wdata_v;
  int  cpu_drop, dbg_drop;
  bit  found;
  int  g;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_cycle(input int t);
    bit win, we;
    logic [7:0] a, d;
    if (rst) begin
      for (int i = t + 1; i < NC; i++) begin
        exp_cg[i] = 0; exp_dg[i] = 0; exp_wr[i] = 0; exp_re[i] = 0; exp_crv[i] = 0; exp_drv[i] = 0;
        ev_a[i] = 0; ev_w[i] = 0; ev_r[i] = 0;
      end
      ev_a[t+1] = 1; ev_av[t+1] = 8'h00;
      ev_w[t+1] = 1; ev_wv[t+1] = 8'h00;
      ev_r[t+1] = 1; ev_rv[t+1] = 8'h00;
      free_at = t + 1;
      last_dbg = 0;
    end else if (t >= free_at && (cpu_pend || dbg_pend)) begin
      if (cpu_pend && dbg_pend) win = RR ? !last_dbg : 1'b1;
      else win = dbg_pend;
      last_dbg = win;
      we = win ? dbg_we_v : cpu_we_v;
      a  = win ? dbg_addr_v : cpu_addr_v;
      d  = win ? dbg_wdata_v : cpu_wdata_v;
      exp_cg[t+1] = !win; exp_dg[t+1] = win; exp_wr[t+1] = we; exp_re[t+1] = !we;
      ev_a[t+1] = 1; ev_av[t+1] = a;
      ev_w[t+1] = 1; ev_wv[t+1] = d;
      if (we) begin
        ref_mem[a] = d;
        free_at = t + 2;
      end else begin
        exp_crv[t+3] = !win; exp_drv[t+3] = win;
        ev_r[t+3] = 1; ev_rv[t+3] = ref_mem[a];
        free_at = t + 3;
      end
      if (win) begin dbg_gr = 1; dbg_drop = t + 2; end
      else begin cpu_gr = 1; cpu_drop = t + 2; end
    end
  endtask

  // one clock cycle: check outputs, drive requests, advance model, advance clock
  task automatic step(input bit rnd);
    if (ev_a[cyc]) cur_a = ev_av[cyc];
    if (ev_w[cyc]) cur_w = ev_wv[cyc];
    if (ev_r[cyc]) cur_r = ev_rv[cyc];
    chk("cpu_gnt", bus.cpu_gnt, exp_cg[cyc]);
    chk("dbg_gnt", bus.dbg_gnt, exp_dg[cyc]);
    chk("en_wr", bus.en_DM_wr, exp_wr[cyc]);
    chk("en_rd", bus.en_DM_rd, exp_re[cyc]);
    chk("cpu_rvalid", bus.cpu_rvalid, exp_crv[cyc]);
    chk("dbg_rvalid", bus.dbg_rvalid, exp_drv[cyc]);
    chk("dm_addr", bus.dm_addr, cur_a);
    chk("dm_wdata", bus.dm_wdata, cur_w);
    chk("rd_data", bus.rd_data, cur_r);
    if (rnd && !cpu_pend && $urandom_range(0, 2) == 0) begin
      cpu_pend = 1; cpu_we_v = 1'($urandom_range(0, 1));
      cpu_addr_v = 8'($urandom_range(0, 15)); cpu_wdata_v = 8'($urandom);
    end
    if (rnd && !dbg_pend && $urandom_range(0, 2) == 0) begin
      dbg_pend = 1; dbg_we_v = 1'($urandom_range(0, 1));
      dbg_addr_v = 8'($urandom_range(0, 15)); dbg_wdata_v = 8'($urandom);
    end
    bus.cpu_req = cpu_pend; bus.cpu_we = cpu_we_v; bus.cpu_addr = cpu_addr_v; bus.cpu_wdata = cpu_wdata_v;
    bus.dbg_req = dbg_pend; bus.dbg_we = dbg_we_v; bus.dbg_addr = dbg_addr_v; bus.dbg_wdata = dbg_wdata_v;
    model_cycle(cyc);
    @(posedge clk); #1;
    cyc++;
    if (cpu_gr && cyc >= cpu_drop) begin cpu_pend = 0; cpu_gr = 0; end
    if (dbg_gr && cyc >= dbg_drop) begin dbg_pend = 0; dbg_gr = 0; end
  endtask

  task automatic wait_gnt(input bit dbg, input string tag);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(1'b0);
      found = dbg ? (bus.dbg_gnt === 1'b1) : (bus.cpu_gnt === 1'b1);
    end
    chk(tag, 8'(found), 8'h01);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
    cpu_pend = 0; dbg_pend = 0; cpu_gr = 0; dbg_gr = 0;
    cpu_we_v = 0; dbg_we_v = 0;
    cpu_addr_v = 0; cpu_wdata_v = 0; dbg_addr_v = 0; dbg_wdata_v = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    cur_a = 0; cur_w = 0; cur_r = 0; free_at = 0; last_dbg = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0);
    rst = 0;
    // CPU write 0xA5 to 0x12
    cpu_pend = 1; cpu_we_v = 1; cpu_addr_v = 8'h12; cpu_wdata_v = 8'hA5;
    step(1'b0);
    chk("w_gnt", bus.cpu_gnt, 8'h01);
    chk("w_en_wr", bus.en_DM_wr, 8'h01);
    chk("w_addr", bus.dm_addr, 8'h12);
    chk("w_wdata", bus.dm_wdata, 8'hA5);
    step(1'b0);
    chk("w_idle_gnt", bus.cpu_gnt, 8'h00);
    chk("w_idle_en", bus.en_DM_wr, 8'h00);
    // CPU read back from 0x12
    cpu_pend = 1; cpu_we_v = 0; cpu_addr_v = 8'h12;
    step(1'b0);
    chk("r_gnt", bus.cpu_gnt, 8'h01);
    chk("r_en_rd", bus.en_DM_rd, 8'h01);
    step(1'b0);
    step(1'b0);
    chk("r_rvalid", bus.cpu_rvalid, 8'h01);
    chk("r_data", bus.rd_data, 8'hA5);
    // simultaneous reads: dbg first, cpu three cycles later
    cpu_pend = 1; cpu_we_v = 0; cpu_addr_v = 8'h20;
    dbg_pend = 1; dbg_we_v = 0; dbg_addr_v = 8'h21;
    wait_gnt(1'b1, "both_dbg_first");
    chk("both_cpu_waits", bus.cpu_gnt, 8'h00);
    g = cyc;
    wait_gnt(1'b0, "both_cpu_later");
    chk("both_gap", 8'(cyc - g), 8'h03);
    repeat (4) step(1'b0);
    // reset during the RESP cycle of a dbg read discards the response
    dbg_pend = 1; dbg_we_v = 0; dbg_addr_v = 8'h12;
    wait_gnt(1'b1, "rst_dbg_gnt");
    step(1'b0);
    rst = 1;
    cpu_pend = 1; cpu_we_v = 1; cpu_addr_v = 8'h05; cpu_wdata_v = 8'h77;
    step(1'b0);
    rst = 0;
    chk("rst_no_rvalid", bus.dbg_rvalid, 8'h00);
    chk("rst_no_gnt", bus.cpu_gnt, 8'h00);
    chk("rst_addr", bus.dm_addr, 8'h00);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    repeat (4) step(1'b0);
    // random traffic with occasional reset pulses
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(1'b1);
    end
    rst = 0;
    repeat (6) step(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
